// File: rtl/sys_defs.sv
// Shared types and constants for the branch predictor slice.
//   PC_t       : 32-bit program counter
//   cnt2_t     : 2-bit saturating direction counter
//   CNT_RESET  : counter value after reset (weakly not-taken)
//   PC_OFFSET  : lowest PC bit used for table indexing
//   PC_STEP    : fall-through increment for sequential fetch
package sys_defs;

  typedef logic [31:0] PC_t;
  typedef logic [1:0]  cnt2_t;

  localparam cnt2_t       CNT_RESET = 2'b01;
  localparam int unsigned PC_OFFSET = 2;
  localparam PC_t         PC_STEP   = 32'd4;

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch-lookup and retire-update bundle for branch_predictor.
//   fetch_valid/fetch_pc         : lookup requests (master -> slave)
//   predict_taken/predict_target : lookup answers, same cycle (slave -> master)
//   upd_valid/upd_source_pc/
//   upd_target_pc/upd_taken      : committed branch outcomes, port 0 oldest
interface branch_predictor_if
  import sys_defs::*;
#(
  parameter int unsigned WIDTH = 3
) ();

  logic [WIDTH-1:0] fetch_valid;
  PC_t              fetch_pc       [WIDTH];
  logic [WIDTH-1:0] predict_taken;
  PC_t              predict_target [WIDTH];

  logic [WIDTH-1:0] upd_valid;
  PC_t              upd_source_pc  [WIDTH];
  PC_t              upd_target_pc  [WIDTH];
  logic [WIDTH-1:0] upd_taken;

  modport master (
    output fetch_valid, fetch_pc,
    output upd_valid, upd_source_pc, upd_target_pc, upd_taken,
    input  predict_taken, predict_target
  );

  modport slave (
    input  fetch_valid, fetch_pc,
    input  upd_valid, upd_source_pc, upd_target_pc, upd_taken,
    output predict_taken, predict_target
  );

endinterface

// File: rtl/sat_counter2.sv
// Next-state function of a 2-bit saturating direction counter.
//   cnt      : current counter value
//   taken    : resolved direction
//   cnt_next : counter after one training step (11 and 00 saturate)
module sat_counter2
  import sys_defs::*;
(
  input  cnt2_t cnt,
  input  logic  taken,
  output cnt2_t cnt_next
);

  always_comb begin
    cnt_next = cnt;
    if (taken) begin
      if (cnt != 2'b11) cnt_next = cnt + 2'd1;
    end else begin
      if (cnt != 2'b00) cnt_next = cnt - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Bimodal PHT + direct-mapped BTB branch predictor.
// Serves WIDTH zero-latency fetch lookups from the registered tables and
// trains both tables from WIDTH retire updates per cycle.
//   clock : system clock
//   reset : synchronous active-high reset (drops same-cycle updates)
//   bus   : branch_predictor_if slave (fetch lookups + retire updates)
// Optional: define GSHARE_EN to hash PHT indices with a committed global
// history register of HIST_BITS bits.
module branch_predictor
  import sys_defs::*;
#(
  parameter int unsigned WIDTH        = 3,
  parameter int unsigned PHT_IDX_BITS = 7,
  parameter int unsigned BTB_IDX_BITS = 5,
  parameter int unsigned HIST_BITS    = 7
) (
  input  logic               clock,
  input  logic               reset,
  branch_predictor_if.slave  bus
);

  localparam int unsigned PHT_ENTRIES = 1 << PHT_IDX_BITS;
  localparam int unsigned BTB_ENTRIES = 1 << BTB_IDX_BITS;
  localparam int unsigned TAG_BITS    = 32 - BTB_IDX_BITS - PC_OFFSET;

  cnt2_t               pht        [PHT_ENTRIES];
  logic                btb_valid  [BTB_ENTRIES];
  logic [TAG_BITS-1:0] btb_tag    [BTB_ENTRIES];
  PC_t                 btb_target [BTB_ENTRIES];

  logic [PHT_IDX_BITS-1:0] fetch_hash;
  logic [PHT_IDX_BITS-1:0] upd_hash [WIDTH];
  logic [PHT_IDX_BITS-1:0] upd_idx  [WIDTH];
  cnt2_t                   upd_cnt  [WIDTH];

`ifdef GSHARE_EN
  logic [HIST_BITS-1:0] ghr;
  logic [HIST_BITS-1:0] ghr_next;
  logic [HIST_BITS-1:0] hist;
  logic [HIST_BITS-1:0] upd_hist [WIDTH];

  // Each update port sees history with all older same-cycle outcomes shifted in.
  always_comb begin
    hist = ghr;
    for (int i = 0; i < int'(WIDTH); i++) begin
      upd_hist[i] = hist;
      if (bus.upd_valid[i]) hist = HIST_BITS'({hist, bus.upd_taken[i]});
    end
    ghr_next = hist;
  end

  always_ff @(posedge clock) begin
    if (reset) ghr <= '0;
    else       ghr <= ghr_next;
  end

  assign fetch_hash = PHT_IDX_BITS'(ghr);

  always_comb begin
    for (int i = 0; i < int'(WIDTH); i++) upd_hash[i] = PHT_IDX_BITS'(upd_hist[i]);
  end
`else
  assign fetch_hash = '0;

  always_comb begin
    for (int i = 0; i < int'(WIDTH); i++) upd_hash[i] = '0;
  end
`endif

  // Lookup: reads registered tables only, so same-cycle updates are not visible.
  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_fetch
    logic [PHT_IDX_BITS-1:0] pidx;
    logic [BTB_IDX_BITS-1:0] bidx;
    logic                    hit;
    logic                    taken;

    assign pidx  = bus.fetch_pc[i][PC_OFFSET +: PHT_IDX_BITS] ^ fetch_hash;
    assign bidx  = bus.fetch_pc[i][PC_OFFSET +: BTB_IDX_BITS];
    assign hit   = btb_valid[bidx] && (btb_tag[bidx] == bus.fetch_pc[i][31 -: TAG_BITS]);
    assign taken = bus.fetch_valid[i] && hit && pht[pidx][1];

    assign bus.predict_taken[i]  = taken;
    assign bus.predict_target[i] = taken ? btb_target[bidx] : bus.fetch_pc[i] + PC_STEP;
  end

  // Update chain: port i starts from the counter left by the youngest older
  // port that hit the same PHT index this cycle, else from the table.
  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_upd
    logic [PHT_IDX_BITS-1:0] idx;
    cnt2_t                   cin;
    cnt2_t                   cout;

    assign idx = bus.upd_source_pc[i][PC_OFFSET +: PHT_IDX_BITS] ^ upd_hash[i];

    if (i == 0) begin : g_first
      assign cin = pht[idx];
    end else begin : g_chain
      for (genvar j = 0; j < i; j++) begin : g_fwd
        cnt2_t v;
        if (j == 0) begin : g_base
          assign v = (bus.upd_valid[0] && (g_upd[0].idx == idx)) ? g_upd[0].cout : pht[idx];
        end else begin : g_next
          assign v = (bus.upd_valid[j] && (g_upd[j].idx == idx)) ? g_upd[j].cout : g_fwd[j-1].v;
        end
      end
      assign cin = g_fwd[i-1].v;
    end

    sat_counter2 u_cnt (
      .cnt      (cin),
      .taken    (bus.upd_taken[i]),
      .cnt_next (cout)
    );

    assign upd_idx[i] = idx;
    assign upd_cnt[i] = cout;
  end

  // Table state; later ports override earlier ones on the same index.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int e = 0; e < int'(PHT_ENTRIES); e++) pht[e] <= CNT_RESET;
      for (int e = 0; e < int'(BTB_ENTRIES); e++) btb_valid[e] <= 1'b0;
    end else begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (bus.upd_valid[i]) begin
          pht[upd_idx[i]] <= upd_cnt[i];
          if (bus.upd_taken[i]) begin
            btb_valid [bus.upd_source_pc[i][PC_OFFSET +: BTB_IDX_BITS]] <= 1'b1;
            btb_tag   [bus.upd_source_pc[i][PC_OFFSET +: BTB_IDX_BITS]] <= bus.upd_source_pc[i][31 -: TAG_BITS];
            btb_target[bus.upd_source_pc[i][PC_OFFSET +: BTB_IDX_BITS]] <= bus.upd_target_pc[i];
          end
        end
      end
    end
  end

  // Instruction-alignment bits of retired PCs carry no index or tag information.
  logic unused_pc_low;
  always_comb begin
    unused_pc_low = 1'b0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      unused_pc_low = unused_pc_low ^ (^bus.upd_source_pc[i][1:0]);
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (default bimodal build).
module tb_branch_predictor;
  import sys_defs::*;

  localparam int unsigned WIDTH = 3;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  branch_predictor_if #(.WIDTH(WIDTH)) bus ();

  branch_predictor #(
    .WIDTH        (WIDTH),
    .PHT_IDX_BITS (7),
    .BTB_IDX_BITS (5),
    .HIST_BITS    (7)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one cycle; inputs change 1 time unit after the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_upd();
    bus.upd_valid = '0;
    bus.upd_taken = '0;
    for (int p = 0; p < int'(WIDTH); p++) begin
      bus.upd_source_pc[p] = 32'h0;
      bus.upd_target_pc[p] = 32'h0;
    end
  endtask

  task automatic set_upd(input int p, input PC_t pc, input PC_t tgt, input logic tk);
    bus.upd_valid[p]     = 1'b1;
    bus.upd_taken[p]     = tk;
    bus.upd_source_pc[p] = pc;
    bus.upd_target_pc[p] = tgt;
  endtask

  task automatic fetch_all(input PC_t pc);
    for (int p = 0; p < int'(WIDTH); p++) begin
      bus.fetch_valid[p] = 1'b1;
      bus.fetch_pc[p]    = pc;
    end
  endtask

  // Compare one lookup port against its expected direction and target.
  task automatic check_port(input string tag, input int p, input logic tk, input PC_t tgt);
    #1;
    check({tag, "_taken"},  32'(bus.predict_taken[p]), 32'(tk));
    check({tag, "_target"}, bus.predict_target[p], tgt);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_upd();
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    bus.fetch_valid = '0;
    for (int p = 0; p < int'(WIDTH); p++) bus.fetch_pc[p] = 32'h0;
    do_reset();

    // Cold tables: nothing predicted taken.
    fetch_all(32'h100);
    #1;
    check("reset_taken_vec", 32'(bus.predict_taken), 32'h0);
    check_port("reset_p0", 0, 1'b0, 32'h104);
    check_port("reset_p2", 2, 1'b0, 32'h104);

    // Same-cycle update is invisible; next cycle it predicts taken.
    set_upd(0, 32'h100, 32'h200, 1'b1);
    check_port("same_cycle", 0, 1'b0, 32'h104);
    step();
    clear_upd();
    #1;
    check("trained_taken_vec", 32'(bus.predict_taken), 32'h7);
    check_port("trained_p1", 1, 1'b1, 32'h200);

    // Saturation: five taken -> 11.
    do_reset();
    set_upd(0, 32'h100, 32'h200, 1'b1);
    repeat (5) step();
    clear_upd();
    check_port("sat_11", 0, 1'b1, 32'h200);
    set_upd(0, 32'h100, 32'h0, 1'b0);
    step();
    clear_upd();
    check_port("sat_10", 0, 1'b1, 32'h200);
    set_upd(0, 32'h100, 32'h0, 1'b0);
    step();
    clear_upd();
    check_port("sat_01", 0, 1'b0, 32'h104);
    set_upd(0, 32'h100, 32'h0, 1'b0);
    repeat (2) step();
    set_upd(0, 32'h100, 32'h200, 1'b1);
    step();
    clear_upd();
    check_port("sat_00_then_t", 0, 1'b0, 32'h104);
    set_upd(0, 32'h100, 32'h200, 1'b1);
    step();
    clear_upd();
    check_port("sat_01_then_t", 0, 1'b1, 32'h200);

    // Two ports, same PC, one cycle: counter 01 -> 11, port 1 target wins.
    do_reset();
    set_upd(0, 32'h100, 32'h200, 1'b1);
    set_upd(1, 32'h100, 32'h300, 1'b1);
    step();
    clear_upd();
    check_port("dual_port", 0, 1'b1, 32'h300);
    set_upd(0, 32'h100, 32'h0, 1'b0);
    step();
    clear_upd();
    check_port("dual_is_11", 0, 1'b1, 32'h300);

    // Tag alias on port 1, idle port 2.
    bus.fetch_pc[1]    = 32'h180;
    bus.fetch_valid[2] = 1'b0;
    check_port("alias_p1", 1, 1'b0, 32'h184);
    check_port("idle_p2", 2, 1'b0, 32'h104);
    check("alias_taken_vec", 32'(bus.predict_taken), 32'h1);

    // Three ports on 0x600 (same BTB set as 0x100): port 2 target wins.
    fetch_all(32'h600);
    set_upd(0, 32'h600, 32'h700, 1'b1);
    set_upd(1, 32'h600, 32'h800, 1'b1);
    set_upd(2, 32'h600, 32'h900, 1'b1);
    step();
    clear_upd();
    check_port("triple_port", 0, 1'b1, 32'h900);
    bus.fetch_pc[1] = 32'h100;
    check_port("evicted_100", 1, 1'b0, 32'h104);

    // Not-taken update keeps BTB target; counter 11 -> 10.
    set_upd(0, 32'h600, 32'hABC, 1'b0);
    step();
    clear_upd();
    check_port("nt_keeps_btb", 0, 1'b1, 32'h900);

    // Invalid port ignored entirely.
    bus.upd_valid[1]     = 1'b0;
    bus.upd_taken[1]     = 1'b1;
    bus.upd_source_pc[1] = 32'h400;
    bus.upd_target_pc[1] = 32'h500;
    step();
    step();
    clear_upd();
    bus.fetch_pc[2] = 32'h400;
    check_port("invalid_ignored", 2, 1'b0, 32'h404);

    // Reset wins over a same-cycle update.
    reset = 1'b1;
    set_upd(0, 32'h800, 32'h880, 1'b1);
    set_upd(1, 32'h800, 32'h880, 1'b1);
    step();
    reset = 1'b0;
    clear_upd();
    bus.fetch_pc[0] = 32'h800;
    bus.fetch_pc[1] = 32'h600;
    check_port("reset_drops_upd", 0, 1'b0, 32'h804);
    check_port("reset_clears_btb", 1, 1'b0, 32'h604);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Consumer end of the retire-side update interface. Each cycle it takes up to WIDTH committed branch outcomes (valid, source_pc, target_pc, taken) and trains a bimodal pattern history table (PHT) and a direct-mapped branch target buffer (BTB).
- Also serves WIDTH same-cycle fetch lookups, returning predicted direction and next PC.
- Sits between fetch (lookup side) and ROB retire (update side).

Parameters:
- WIDTH, 3, number of fetch lookup ports and number of update ports.
- PHT_IDX_BITS, 7, log2 of PHT entries (128 two-bit counters).
- BTB_IDX_BITS, 5, log2 of BTB entries (32).
- HIST_BITS, 7, global history length; used only with GSHARE_EN; must be ≤ PHT_IDX_BITS.

Ports:
- clock, input, 1, system clock.
- reset, input, 1, synchronous active-high reset.
- fetch_valid, input, WIDTH, lookup request per port.
- fetch_pc, input, PC_t[WIDTH], lookup PCs.
- predict_taken, output, WIDTH, predicted taken.
- predict_target, output, PC_t[WIDTH], predicted next PC.
- upd_valid, input, WIDTH, retire update valid; port 0 is oldest.
- upd_source_pc, input, PC_t[WIDTH], PC of the retired branch.
- upd_target_pc, input, PC_t[WIDTH], resolved target.
- upd_taken, input, WIDTH, resolved direction.

Behaviour:
- PC_t is 32 bits. Index bits start at pc[2].
  - pht_idx = pc[PHT_IDX_BITS+1:2].
  - btb_idx = pc[BTB_IDX_BITS+1:2].
  - btb_tag = pc[31:BTB_IDX_BITS+2].
- Lookup is combinational, zero latency, and reads the registered tables only.
  - A same-cycle update is NOT visible to the lookup; it becomes visible the next cycle.
- BTB hit = entry valid && tag match.
- predict_taken[i] = fetch_valid[i] && hit && pht[pht_idx][1].
- predict_target[i] = btb target if predict_taken[i], else fetch_pc[i]+4.
- With fetch_valid[i]=0: predict_taken[i]=0 and predict_target[i]=fetch_pc[i]+4.
- PHT counter update for each valid port, in port order 0..WIDTH-1 within one cycle:
  - taken: saturating increment, 2'b11 holds.
  - not taken: saturating decrement, 2'b00 holds.
- Several valid ports hitting the same PHT index in one cycle compose sequentially.
  - Example: two taken updates from 01 give 11 next cycle.
- BTB update: a taken update writes valid=1, tag and target_pc. A not-taken update leaves the BTB unchanged.
- Several taken ports hitting the same BTB index in one cycle: the highest-numbered port wins.
- upd_valid[i]=0 means every other field on port i is ignored.
- Reset:
  - all PHT counters = 2'b01 (weakly not-taken);
  - all BTB valid bits = 0; BTB tag and target contents are don't-care;
  - GHR = 0.
- Outputs are combinational, so after reset predict_taken=0 for all ports.
- Reset asserted in the same cycle as updates: reset wins and the updates are dropped.

Optional Feature:
- Macro GSHARE_EN.
- Defined: a HIST_BITS global history register (GHR) holds committed history.
  - Lookup PHT index = pht_idx XOR zero-extended GHR. All fetch ports use the current registered GHR.
  - Update port i uses the GHR value after shifting in taken bits of valid ports 0..i-1 of the same cycle.
  - GHR next = GHR shifted left by the count of valid ports, with taken bits inserted oldest first.
  - The GHR is updated for not-taken branches as well.
- Undefined: no GHR; plain bimodal indexing as above.

Decomposition:
- Shared package (sys_defs): PC_t, the 2-bit counter type, and the constants for the reset counter value (2'b01) and the PC offset (2).
- One natural sub-module: sat_counter2, a combinational next-state function for the 2-bit counter, instantiated per update port in the sequential chain.
- The BTB and PHT arrays stay inline.

Test Plan:
- Reset, then fetch pc=0x100 on all ports -> predict_taken=000, predict_target=0x104.
- Retire taken, pc=0x100, target=0x200; next cycle fetch 0x100 -> counter 10, BTB hit, predict_taken=1, target=0x200.
- Same-cycle update and lookup of 0x100 from reset -> the lookup in that cycle returns not-taken/0x104; the next cycle returns taken/0x200.
- Ports 0 and 1 both retire taken pc=0x100 with targets 0x200 and 0x300 -> counter 01→11, BTB target 0x300.
- Saturation:
  - Five taken updates -> counter 11.
  - Then one not-taken -> 10, still predicted taken.
  - Then three more not-taken -> 00, and a subsequent taken update -> 01 (predicts not-taken).
- BTB alias: pc 0x100 installed, fetch 0x100+(1<<(BTB_IDX_BITS+2)) -> tag mismatch, not taken, target pc+4.
- With GSHARE_EN: retire taken, not-taken, taken on ports 0..2 from GHR=0 -> GHR=3'b101 (zero-extended). Port 2 trains index pht_idx^2'b10.
